// File: rtl/reg_timeout_guard.sv
// ============================================================================
// Module      : reg_timeout_guard
// Description : Register-bus slice that bounds each downstream access with a
//               timeout and answers hung accesses with an error response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_timeout_guard #(
   parameter int          ADDR_WIDTH     = 32,
   parameter int          DATA_WIDTH     = 32,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_DATA       = 32'hBADCAB1E,
   parameter int          STAT_WIDTH     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   input  logic                    in_write_i,
   input  logic [ADDR_WIDTH-1:0]   in_addr_i,
   input  logic [DATA_WIDTH-1:0]   in_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] in_wstrb_i,
   output logic                    in_ready_o,
   output logic [DATA_WIDTH-1:0]   in_rdata_o,
   output logic                    in_error_o,
   output logic                    out_valid_o,
   output logic                    out_write_o,
   output logic [ADDR_WIDTH-1:0]   out_addr_o,
   output logic [DATA_WIDTH-1:0]   out_wdata_o,
   output logic [DATA_WIDTH/8-1:0] out_wstrb_o,
   input  logic                    out_ready_i,
   input  logic [DATA_WIDTH-1:0]   out_rdata_i,
   input  logic                    out_error_i,
   input  logic                    tmo_en_i,
   input  logic                    tmo_clr_i,
   output logic                    tmo_irq_o,
   output logic [STAT_WIDTH-1:0]   tmo_count_o,
   output logic [ADDR_WIDTH-1:0]   tmo_addr_o
);

   localparam int c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_CW-1:0]       c_CNT_MAX  = c_CW'(TIMEOUT_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] c_ERR_DATA = DATA_WIDTH'(ERR_DATA);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_BUSY  = 2'd1;
   localparam logic [1:0] c_RESP  = 2'd2;
   localparam logic [1:0] c_ABORT = 2'd3;

   logic [1:0]              state_q, state_d;
   logic [c_CW-1:0]         cnt_q, cnt_d;
   logic                    write_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    error_q;
   logic [STAT_WIDTH-1:0]   tmo_count_q;
   logic [ADDR_WIDTH-1:0]   tmo_addr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= c_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A completion arriving in the expiry cycle takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         c_IDLE: begin
            if (in_valid_i) begin
               state_d = c_BUSY;
               cnt_d   = '0;
            end
         end
         c_BUSY: begin
            if (out_ready_i) begin
               state_d = c_RESP;
            end else if (tmo_en_i) begin
               if (cnt_q == c_CNT_MAX) state_d = c_ABORT;
               else                    cnt_d   = cnt_q + c_CW'(1);
            end
         end
         c_RESP:  state_d = c_IDLE;
         c_ABORT: state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      out_valid_o = 1'b0;
      in_ready_o  = 1'b0;
      in_rdata_o  = '0;
      in_error_o  = 1'b0;
      tmo_irq_o   = 1'b0;
      case (state_q)
         c_BUSY: out_valid_o = 1'b1;
         c_RESP: begin
            in_ready_o = 1'b1;
            in_rdata_o = rdata_q;
            in_error_o = error_q;
         end
         c_ABORT: begin
            in_ready_o = 1'b1;
            in_rdata_o = c_ERR_DATA;
            in_error_o = 1'b1;
            tmo_irq_o  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         if (state_q == c_IDLE && in_valid_i) begin
            write_q <= in_write_i;
            addr_q  <= in_addr_i;
            wdata_q <= in_wdata_i;
            wstrb_q <= in_wstrb_i;
         end
         if (state_q == c_BUSY && out_ready_i) begin
            rdata_q <= out_rdata_i;
            error_q <= out_error_i;
         end
      end
   end

   // A clear coinciding with a timeout still records that timeout.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_count_q <= '0;
         tmo_addr_q  <= '0;
      end else if (state_q == c_ABORT) begin
         tmo_addr_q <= addr_q;
         if (tmo_clr_i)
            tmo_count_q <= STAT_WIDTH'(1);
         else if (tmo_count_q != {STAT_WIDTH{1'b1}})
            tmo_count_q <= tmo_count_q + STAT_WIDTH'(1);
      end else if (tmo_clr_i) begin
         tmo_count_q <= '0;
         tmo_addr_q  <= '0;
      end
   end

   assign out_write_o = write_q;
   assign out_addr_o  = addr_q;
   assign out_wdata_o = wdata_q;
   assign out_wstrb_o = wstrb_q;
   assign tmo_count_o = tmo_count_q;
   assign tmo_addr_o  = tmo_addr_q;

endmodule

`default_nettype wire
